lsu_mem_master: RTL and testbench

//  Initiator side of the byte-addressed data-memory request interface (r_v/w_v/adr/data/strobe -> resp/ack).

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_mem_master_if.sv | 49 ++++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/lsu_mem_master.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Size, error and state encodings plus the alignment rule.
package lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Encoding 3 is not a legal size and is reported like a misaligned access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
        logic mis;
        mis = 1'b1;
        case (size_e'(size))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and data-memory signals of the load/store master.
// master = the LSU itself, slave = the core/memory environment around it.
interface lsu_mem_master_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) ();

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_rdata;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;

    logic             mem_r_v;
    logic             mem_w_v;
    logic [XLEN-1:0]  mem_adr;
    logic [XLEN-1:0]  mem_data;
    logic [3:0]       mem_strobe;
    logic [XLEN-1:0]  mem_resp;
    logic             mem_ack;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_tag, rsp_err,
        input  rsp_ready,
        output mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
        input  mem_resp, mem_ack
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_tag, rsp_err,
        output rsp_ready,
        input  mem_r_v, mem_w_v, mem_adr, mem_data, mem_strobe,
        output mem_resp, mem_ack
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: write strobes, store data replication and
// load data extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    // Each lane carries the byte of the store operand that lands on it.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wdata_o[8*gi +: 8] =
                (size_i == 2'd0) ? wdata_i[7:0] :
                (size_i == 2'd1) ? wdata_i[8*(gi % 2) +: 8] :
                                   wdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        strobe_o = 4'b0000;
        if (we_i) begin
            case (size_e'(size_i))
                SZ_B:    strobe_o = 4'b0001 << off_i;
                SZ_H:    strobe_o = 4'b0011 << off_i;
                default: strobe_o = 4'b1111;
            endcase
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword_i[7:0];
        case (off_i)
            2'd0: byte_sel = rword_i[7:0];
            2'd1: byte_sel = rword_i[15:8];
            2'd2: byte_sel = rword_i[23:16];
            2'd3: byte_sel = rword_i[31:24];
            default: byte_sel = rword_i[7:0];
        endcase
        half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        rdata_o = rword_i;
        case (size_e'(size_i))
            SZ_B:    rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_H:    rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store master: accepts one core request, issues a word-aligned memory
// access, waits for ack or timeout, and returns an aligned, tagged response.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT     = 64,
    parameter int ACK_MIN_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_mem_master_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACK_MIN  = CNT_W'(ACK_MIN_LAT);

    state_e           state_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             mem_r_v_q;
    logic             mem_w_v_q;
    logic             we_q;
    logic             unsigned_q;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  adr_q;
    logic [XLEN-1:0]  data_q;
    logic [XLEN-1:0]  rdata_q;
    logic [3:0]       strobe_q;
    err_e             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Lane logic sees the live request while idle and the captured one afterwards.
    logic             idle;
    logic             al_we;
    logic             al_unsigned;
    logic [1:0]       al_size;
    logic [1:0]       al_off;
    logic [3:0]       al_strobe;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_rdata;

    assign idle        = (state_q == IDLE);
    assign al_we       = idle ? bus.req_we         : we_q;
    assign al_unsigned = idle ? bus.req_unsigned   : unsigned_q;
    assign al_size     = idle ? bus.req_size       : size_q;
    assign al_off      = idle ? bus.req_addr[1:0]  : off_q;
    assign cnt_d       = cnt_q + 1'b1;

    lsu_lane_align u_align (
        .we_i       (al_we),
        .size_i     (al_size),
        .off_i      (al_off),
        .unsigned_i (al_unsigned),
        .wdata_i    (bus.req_wdata),
        .rword_i    (bus.mem_resp),
        .strobe_o   (al_strobe),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mem_r_v_q   <= 1'b0;
            mem_w_v_q   <= 1'b0;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= 2'd0;
            tag_q       <= '0;
            adr_q       <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            strobe_q    <= 4'b0000;
            err_q       <= ERR_OK;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we;
                        unsigned_q  <= bus.req_unsigned;
                        size_q      <= bus.req_size;
                        off_q       <= bus.req_addr[1:0];
                        tag_q       <= bus.req_tag;
                        adr_q       <= {bus.req_addr[XLEN-1:2], 2'b00};
                        data_q      <= al_wdata;
                        rdata_q     <= '0;
                        cnt_q       <= '0;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= ERR_MISALIGN;
                        end else begin
                            state_q   <= ISSUE;
                            err_q     <= ERR_OK;
                            mem_r_v_q <= ~bus.req_we;
                            mem_w_v_q <= bus.req_we;
                            strobe_q  <= al_strobe;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_d;
                    // A qualified ack takes priority over a timeout on the same edge.
                    if (bus.mem_ack && (cnt_q >= ACK_MIN)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        mem_r_v_q   <= 1'b0;
                        mem_w_v_q   <= 1'b0;
                        strobe_q    <= 4'b0000;
                        err_q       <= ERR_OK;
                        rdata_q     <= we_q ? '0 : al_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        mem_r_v_q   <= 1'b0;
                        mem_w_v_q   <= 1'b0;
                        strobe_q    <= 4'b0000;
                        err_q       <= ERR_TIMEOUT;
                        rdata_q     <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_r_v_q   <= 1'b0;
                    mem_w_v_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_err    = err_q;
    assign bus.mem_r_v    = mem_r_v_q;
    assign bus.mem_w_v    = mem_w_v_q;
    assign bus.mem_adr    = adr_q;
    assign bus.mem_data   = data_q;
    assign bus.mem_strobe = strobe_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu_mem_master;

    localparam int TIMEOUT     = 64;
    localparam int ACK_MIN_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.XLEN(32), .TAG_W(4)) bus ();

    lsu_mem_master #(
        .XLEN(32), .TAG_W(4), .TIMEOUT(TIMEOUT), .ACK_MIN_LAT(ACK_MIN_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: lanes touched, replicated data and extended load value.
    function automatic logic [3:0] m_strobe(int size, int off);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < (1 << size); i++) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(int size, logic [31:0] w);
        logic [31:0] d;
        int n;
        n = 1 << size;
        d = '0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(w >> (8 * (i % n)));
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] word, int size, int off, bit uns);
        logic [31:0] v;
        v = word >> (8 * off);
        if (size == 0) begin
            v = v & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic do_req(input bit we, input int size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] tag, input logic [31:0] word,
                          input int ack_start, input int rdy_delay);
        int off, n, first, done, exp_done, hold_bad;
        bit mis;
        logic [1:0]  exp_err;
        logic [31:0] exp_rd;
        off = int'(addr[1:0]);
        n   = 1 << size;
        mis = (size == 3) || ((off % n) != 0);

        bus.req_we       = we;
        bus.req_size     = 2'(size);
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_tag      = tag;
        bus.req_valid    = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        done = 0;
        if (mis) begin
            exp_err = 2'd1;
            exp_rd  = '0;
            chk("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        end else begin
            chk("mem_r_v", 32'(bus.mem_r_v), 32'(!we));
            chk("mem_w_v", 32'(bus.mem_w_v), 32'(we));
            chk("mem_adr", bus.mem_adr, addr & 32'hFFFF_FFFC);
            chk("mem_strobe", 32'(bus.mem_strobe), we ? 32'(m_strobe(size, off)) : 32'd0);
            if (we) chk("mem_data", bus.mem_data, m_wdata(size, wdata));
            bus.mem_resp = word;
            first = (ack_start > ACK_MIN_LAT) ? ack_start : ACK_MIN_LAT;
            if (first < TIMEOUT) begin
                exp_done = first;
                exp_err  = 2'd0;
                exp_rd   = we ? 32'd0 : m_load(word, size, off, uns);
            end else begin
                exp_done = TIMEOUT - 1;
                exp_err  = 2'd2;
                exp_rd   = '0;
            end
            done     = -1;
            hold_bad = 0;
            for (int i = 0; i < TIMEOUT + 8; i++) begin
                bus.mem_ack = (i >= ack_start);
                @(posedge clk); #1;
                if (bus.rsp_valid) begin
                    done = i;
                    break;
                end
                if (bus.mem_r_v !== !we || bus.mem_w_v !== we) hold_bad++;
            end
            bus.mem_ack = 1'b0;
            chk("issue_hold", 32'(hold_bad), 32'd0);
            chk("rsp_cycle", 32'(done), 32'(exp_done));
        end

        for (int k = 0; k <= rdy_delay; k++) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("rsp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rsp_mem_idle", 32'({bus.mem_r_v, bus.mem_w_v}), 32'd0);
            if (k < rdy_delay) begin
                @(posedge clk); #1;
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        $display("txn %0d we=%0d size=%0d uns=%0d addr=%h tag=%h ack_start=%0d rdy_delay=%0d exp_err=%0d exp_rdata=%h",
                 txn, we, size, uns, addr, tag, ack_start, rdy_delay, exp_err, exp_rd);
        txn++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit we;
        int size, r, ack_start, rdy;
        logic [31:0] addr;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b0; bus.mem_resp = '0; bus.mem_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_v", 32'({bus.mem_r_v, bus.mem_w_v}), 32'd0);
        chk("rst_strobe", 32'(bus.mem_strobe), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_adr", bus.mem_adr, 32'd0);
        chk("rst_mem_data", bus.mem_data, 32'd0);

        // Directed cases
        do_req(1'b1, 0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 4'h1, 32'h0, 1, 0);
        do_req(1'b0, 1, 1'b0, 32'h0000_0102, 32'h0, 4'h2, 32'h8001_1234, 2, 0);
        do_req(1'b0, 1, 1'b1, 32'h0000_0102, 32'h0, 4'h3, 32'h8001_1234, 3, 0);
        do_req(1'b0, 2, 1'b0, 32'h0000_0101, 32'h0, 4'h4, 32'h0, 1, 0);
        do_req(1'b0, 2, 1'b0, 32'h0000_0200, 32'h0, 4'h5, 32'hDEAD_BEEF, 1000, 0);
        do_req(1'b0, 2, 1'b0, 32'h0000_0204, 32'h0, 4'h6, 32'h1234_5678, TIMEOUT - 1, 0);
        do_req(1'b0, 0, 1'b0, 32'h0000_0301, 32'h0, 4'h7, 32'h0000_9A00, 0, 5);
        do_req(1'b1, 3, 1'b0, 32'h0000_0300, 32'h1111_2222, 4'h8, 32'h0, 1, 1);

        // Reset in the middle of an ISSUE phase drops the request
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h0000_0400; bus.req_tag = 4'h9;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_r_v", 32'(bus.mem_r_v), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_rsp_idle", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 2, 1'b0, 32'h0000_0400, 32'h0, 4'hA, 32'hCAFE_F00D, 2, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            we   = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            size = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << size) - 1);
            ack_start = ($urandom_range(0, 11) == 0) ? 200 : int'($urandom_range(0, 5));
            rdy = int'($urandom_range(0, 3));
            do_req(we, size, 1'($urandom_range(0, 1)), addr, $urandom, 4'(t), $urandom, ack_start, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
